// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter and its timeout timer.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int DEFAULT_TIMEOUT      = 255;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter that flags a hung memory transaction; TIMEOUT = 0 disables it.
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      tmo_cnt <= '0;
    else if (enable)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expire = 1'b0;
    end else begin : g_enabled
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
      // Fires on the TIMEOUT-th busy cycle, counting the first one as zero.
      assign expire = enable && (tmo_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the MEM-stage data
// controller, with data priority, anti-starvation and a hung-transaction abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        I_ReadEnable,
  input  logic [29:0] I_Address,
  output logic [31:0] I_ReadData,
  output logic        I_Ready,
  output logic        I_Error,
  input  logic        D_ReadEnable,
  input  logic [3:0]  D_WriteEnable,
  input  logic [29:0] D_Address,
  input  logic [31:0] D_WriteData,
  output logic [31:0] D_ReadData,
  output logic        D_Ready,
  output logic        D_Error,
  output logic        M_ReadEnable,
  output logic [3:0]  M_WriteEnable,
  output logic [29:0] M_Address,
  output logic [31:0] M_WriteData,
  input  logic [31:0] M_ReadData,
  input  logic        M_Ready
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state, state_next;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic          settle;
  logic          d_write, d_req, busy, done, expire, timer_clear;
  logic          grant_i, grant_d;

  assign d_write     = |D_WriteEnable;
  assign d_req       = D_ReadEnable | d_write;
  assign busy        = (state != IDLE);
  assign timer_clear = !busy || done;
  assign I_ReadData  = M_ReadData;
  assign D_ReadData  = M_ReadData;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (busy),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The settle cycle after a completion never grants, giving a 3-cycle minimum period.
  always_comb begin
    state_next = state;
    owner      = OWNER_D;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    I_Ready    = 1'b0;
    I_Error    = 1'b0;
    D_Ready    = 1'b0;
    D_Error    = 1'b0;
    case (state)
      IDLE: begin
        if (!settle) begin
          if (I_ReadEnable && (starve_cnt == STARVE_MAX || !d_req)) begin
            grant_i = 1'b1;
            owner   = OWNER_I;
          end else if (d_req) begin
            grant_d = 1'b1;
          end
          if (grant_i || grant_d)
            state_next = (owner == OWNER_I) ? BUSY_I : BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        done = M_Ready || expire;
        if (done) state_next = IDLE;
        if (!reset) begin
          if (state == BUSY_I) begin
            I_Ready = M_Ready;
            I_Error = expire && !M_Ready;
          end else begin
            D_Ready = M_Ready;
            D_Error = expire && !M_Ready;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command registers, settle flag and the starvation counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      M_ReadEnable  <= 1'b0;
      M_WriteEnable <= '0;
      M_Address     <= '0;
      M_WriteData   <= '0;
      settle        <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      settle <= done;
      if (grant_i) begin
        M_ReadEnable  <= 1'b1;
        M_WriteEnable <= '0;
        M_Address     <= I_Address;
        M_WriteData   <= '0;
      end else if (grant_d) begin
        M_ReadEnable  <= D_ReadEnable && !d_write;
        M_WriteEnable <= D_WriteEnable;
        M_Address     <= D_Address;
        M_WriteData   <= D_WriteData;
      end else if (done) begin
        M_ReadEnable  <= 1'b0;
        M_WriteEnable <= '0;
      end
      if (state == IDLE) begin
        if (grant_i || !I_ReadEnable)
          starve_cnt <= '0;
        else if (grant_d && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model of the port.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        I_ReadEnable = 1'b0;
  logic [29:0] I_Address = '0;
  logic [31:0] I_ReadData;
  logic        I_Ready, I_Error;
  logic        D_ReadEnable = 1'b0;
  logic [3:0]  D_WriteEnable = '0;
  logic [29:0] D_Address = '0;
  logic [31:0] D_WriteData = '0;
  logic [31:0] D_ReadData;
  logic        D_Ready, D_Error;
  logic        M_ReadEnable;
  logic [3:0]  M_WriteEnable;
  logic [29:0] M_Address;
  logic [31:0] M_WriteData;
  logic [31:0] M_ReadData = '0;
  logic        M_Ready = 1'b0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .I_ReadEnable(I_ReadEnable), .I_Address(I_Address), .I_ReadData(I_ReadData),
    .I_Ready(I_Ready), .I_Error(I_Error),
    .D_ReadEnable(D_ReadEnable), .D_WriteEnable(D_WriteEnable), .D_Address(D_Address),
    .D_WriteData(D_WriteData), .D_ReadData(D_ReadData), .D_Ready(D_Ready), .D_Error(D_Error),
    .M_ReadEnable(M_ReadEnable), .M_WriteEnable(M_WriteEnable), .M_Address(M_Address),
    .M_WriteData(M_WriteData), .M_ReadData(M_ReadData), .M_Ready(M_Ready)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic i_re, input logic [29:0] i_addr, input logic d_re,
                               input logic [3:0] d_we, input logic [29:0] d_addr, input logic [31:0] d_wdata);
    I_ReadEnable  = i_re;
    I_Address     = i_addr;
    D_ReadEnable  = d_re;
    D_WriteEnable = d_we;
    D_Address     = d_addr;
    D_WriteData   = d_wdata;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: who owns the port, how long it has been busy, whether this is
  // the settle cycle after a completion, and how many data grants the fetch side sat through.
  int          m_owner = 0;          // 0 none, 1 fetch, 2 data
  int          m_busy_cycles = 0;
  bit          m_settle = 1'b0;
  int          m_dstreak = 0;
  logic        exp_mre = 1'b0;
  logic [3:0]  exp_mwe = '0;
  logic [29:0] exp_maddr = '0;
  logic [31:0] exp_mwdata = '0;
  bit          model_live = 1'b0;
  bit          log_en = 1'b0;
  logic [29:0] grant_log[$];
  logic        prev_mre = 1'b0;
  int          i_error_pulses = 0;
  int          d_ready_pulses = 0;

  always @(negedge clock) begin
    bit timeout_now;
    bit d_wants;
    if (model_live) begin
      timeout_now = (m_owner != 0) && (TIMEOUT != 0) && (m_busy_cycles == TIMEOUT - 1) && !M_Ready;
      checkOutput("I_Ready",       I_Ready,       !reset && m_owner == 1 && M_Ready);
      checkOutput("D_Ready",       D_Ready,       !reset && m_owner == 2 && M_Ready);
      checkOutput("I_Error",       I_Error,       !reset && m_owner == 1 && timeout_now);
      checkOutput("D_Error",       D_Error,       !reset && m_owner == 2 && timeout_now);
      checkOutput("I_ReadData",    I_ReadData,    M_ReadData);
      checkOutput("D_ReadData",    D_ReadData,    M_ReadData);
      checkOutput("M_ReadEnable",  M_ReadEnable,  exp_mre);
      checkOutput("M_WriteEnable", M_WriteEnable, exp_mwe);
      checkOutput("M_Address",     M_Address,     exp_maddr);
      checkOutput("M_WriteData",   M_WriteData,   exp_mwdata);

      if (D_Ready) d_ready_pulses++;
      if (I_Error) i_error_pulses++;
      if (log_en && M_ReadEnable && !prev_mre) grant_log.push_back(M_Address);
      prev_mre = M_ReadEnable;

      if (reset) begin
        m_owner = 0; m_busy_cycles = 0; m_settle = 1'b0; m_dstreak = 0;
        exp_mre = 1'b0; exp_mwe = '0; exp_maddr = '0; exp_mwdata = '0;
      end else if (m_owner != 0) begin
        if (M_Ready || timeout_now) begin
          m_owner = 0; m_busy_cycles = 0; m_settle = 1'b1;
          exp_mre = 1'b0; exp_mwe = '0;
        end else begin
          m_busy_cycles++;
        end
      end else if (m_settle) begin
        m_settle = 1'b0;
        if (!I_ReadEnable) m_dstreak = 0;
      end else begin
        d_wants = D_ReadEnable || (D_WriteEnable != 4'b0000);
        if (I_ReadEnable && (m_dstreak >= STARVE_LIMIT || !d_wants)) begin
          m_owner = 1; m_dstreak = 0;
          exp_mre = 1'b1; exp_mwe = '0; exp_maddr = I_Address; exp_mwdata = '0;
        end else if (d_wants) begin
          m_owner = 2;
          exp_mwe = D_WriteEnable;
          exp_mre = D_ReadEnable && (D_WriteEnable == 4'b0000);
          exp_maddr = D_Address; exp_mwdata = D_WriteData;
          if (I_ReadEnable) m_dstreak = (m_dstreak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_dstreak + 1;
          else m_dstreak = 0;
        end else begin
          m_dstreak = 0;
        end
      end
    end
  end

  initial begin
    int pulses_before;
    @(posedge clock);
    model_live = 1'b1;
    #1;
    tick();
    $display("[TB] reset values");
    checkOutput("reset M_ReadEnable", M_ReadEnable, 1'b0);
    checkOutput("reset M_WriteEnable", M_WriteEnable, 4'h0);
    checkOutput("reset M_Address", M_Address, 30'h0);
    checkOutput("reset M_WriteData", M_WriteData, 32'h0);
    checkOutput("reset D_Ready", D_Ready, 1'b0);
    reset = 1'b0;
    tick();

    $display("[TB] data write, memory ready after 3 cycles");
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b1111, 30'h0000100, 32'hDEADBEEF);
    tick();
    checkOutput("write M_WriteEnable", M_WriteEnable, 4'b1111);
    checkOutput("write M_Address", M_Address, 30'h0000100);
    checkOutput("write M_WriteData", M_WriteData, 32'hDEADBEEF);
    tick();
    tick();
    M_Ready = 1'b1;
    #1;
    checkOutput("write D_Ready", D_Ready, 1'b1);
    tick();
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    M_Ready = 1'b0;
    checkOutput("write M_WriteEnable cleared", M_WriteEnable, 4'b0000);
    tick();
    tick();
    checkOutput("write D_Ready pulse count", d_ready_pulses, 1);

    $display("[TB] simultaneous fetch and data read");
    applyStimulus(1'b1, 30'h0000200, 1'b1, 4'b0000, 30'h0000300, 32'h0);
    tick();
    checkOutput("dual D M_ReadEnable", M_ReadEnable, 1'b1);
    checkOutput("dual D M_Address", M_Address, 30'h0000300);
    M_Ready = 1'b1;
    M_ReadData = 32'h11112222;
    #1;
    checkOutput("dual D_Ready", D_Ready, 1'b1);
    checkOutput("dual I_Ready held off", I_Ready, 1'b0);
    tick();
    applyStimulus(1'b1, 30'h0000200, 1'b0, 4'b0000, 30'h0, 32'h0);
    M_Ready = 1'b0;
    checkOutput("dual settle M_ReadEnable", M_ReadEnable, 1'b0);
    tick();
    checkOutput("dual no grant in settle", M_ReadEnable, 1'b0);
    tick();
    checkOutput("dual I M_ReadEnable", M_ReadEnable, 1'b1);
    checkOutput("dual I M_Address", M_Address, 30'h0000200);
    M_Ready = 1'b1;
    M_ReadData = 32'hCAFEF00D;
    #1;
    checkOutput("dual I_Ready", I_Ready, 1'b1);
    checkOutput("dual I_ReadData", I_ReadData, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    M_Ready = 1'b0;
    tick();

    $display("[TB] starvation limit with both sides requesting");
    applyStimulus(1'b1, 30'h0000500, 1'b1, 4'b0000, 30'h0000400, 32'h0);
    M_Ready = 1'b1;
    log_en = 1'b1;
    repeat (30) tick();
    log_en = 1'b0;
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    M_Ready = 1'b0;
    checkOutput("starve grant count", grant_log.size(), 10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      checkOutput($sformatf("starve grant %0d", k), grant_log[k],
                  ((k % 5) == 4) ? 30'h0000500 : 30'h0000400);
    tick();
    tick();

    $display("[TB] fetch timeout");
    applyStimulus(1'b1, 30'h0000600, 1'b0, 4'b0000, 30'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    for (int k = 1; k < TIMEOUT; k++) begin
      checkOutput($sformatf("timeout early I_Error %0d", k), I_Error, 1'b0);
      tick();
    end
    checkOutput("timeout I_Error", I_Error, 1'b1);
    checkOutput("timeout I_Ready", I_Ready, 1'b0);
    tick();
    checkOutput("timeout M_ReadEnable cleared", M_ReadEnable, 1'b0);
    tick();
    checkOutput("timeout I_Error pulse count", i_error_pulses, 1);

    $display("[TB] ready coincides with timeout");
    applyStimulus(1'b0, 30'h0, 1'b1, 4'b0000, 30'h0000700, 32'h0);
    tick();
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    repeat (TIMEOUT - 1) tick();
    M_Ready = 1'b1;
    M_ReadData = 32'h55AA55AA;
    #1;
    checkOutput("tie D_Ready", D_Ready, 1'b1);
    checkOutput("tie D_Error", D_Error, 1'b0);
    checkOutput("tie D_ReadData", D_ReadData, 32'h55AA55AA);
    tick();
    M_Ready = 1'b0;
    checkOutput("tie M_ReadEnable cleared", M_ReadEnable, 1'b0);
    tick();

    $display("[TB] reset during data transaction");
    applyStimulus(1'b0, 30'h0, 1'b1, 4'b0011, 30'h0000800, 32'h12345678);
    tick();
    checkOutput("write beats read M_ReadEnable", M_ReadEnable, 1'b0);
    checkOutput("write beats read M_WriteEnable", M_WriteEnable, 4'b0011);
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    tick();
    pulses_before = d_ready_pulses;
    reset = 1'b1;
    tick();
    checkOutput("midreset M_ReadEnable", M_ReadEnable, 1'b0);
    checkOutput("midreset M_WriteEnable", M_WriteEnable, 4'h0);
    checkOutput("midreset M_Address", M_Address, 30'h0);
    checkOutput("midreset M_WriteData", M_WriteData, 32'h0);
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 30'h0000900, 1'b0, 4'b0000, 30'h0, 32'h0);
    tick();
    checkOutput("post-reset M_ReadEnable", M_ReadEnable, 1'b1);
    checkOutput("post-reset M_Address", M_Address, 30'h0000900);
    M_Ready = 1'b1;
    #1;
    checkOutput("post-reset I_Ready", I_Ready, 1'b1);
    checkOutput("midreset no D_Ready", d_ready_pulses, pulses_before);
    tick();
    applyStimulus(1'b0, 30'h0, 1'b0, 4'b0000, 30'h0, 32'h0);
    M_Ready = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
